out_mapper: RTL and testbench

OUT_MAPPER -- requirements
Module: out_mapper

---
 rtl/out_mapper_pkg.sv | 24 ++
 rtl/out_mapper_fifo.sv | 46 ++++
 rtl/out_mapper.sv | 102 ++++++++++
 tb/tb_out_mapper.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_mapper_pkg.sv
// Shared packet layout, type codes and sizing constants for the SpiNNaker-to-AER output mapper.
package out_mapper_pkg;
    localparam int PKT_W     = 72;
    localparam int SHORT_MSB = 39;   // top bit covered by parity when there is no payload

    localparam logic [1:0]  MC_TYPE    = 2'b00;
    localparam int          FIFO_DEPTH = 3;
    localparam logic [7:0]  TO_RELOAD  = 8'd128;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    typedef struct packed {
        logic [31:0] payload;
        logic [31:0] key;
        logic [1:0]  ptype;
        logic [3:0]  rsvd;
        logic        flag;
        logic        parity;
    } pkt_t;

    // Odd parity over the whole packet with payload, otherwise over the short form.
    function automatic logic parity_ok(input logic [PKT_W-1:0] d);
        return d[1] ? ^d : ^d[SHORT_MSB:0];
    endfunction
endpackage

// File: rtl/out_mapper_fifo.sv
// Small first-word-fall-through FIFO; head is always mem[0], entries shift down on pop.
module out_mapper_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    len;
    logic [LW-1:0]    wr_idx;
    logic             push_en;
    logic             pop_en;

    assign empty   = (len == '0);
    assign full    = (len == LW'(DEPTH));
    assign push_en = push & ~full & ~flush;
    assign pop_en  = pop & ~empty;
    // On a simultaneous pop the new entry lands one slot lower, behind the survivors.
    assign wr_idx  = len - LW'(pop_en);
    assign dout    = mem[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        len <= '0;
        else if (flush) len <= '0;
        else            len <= len + LW'(push_en) - LW'(pop_en);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_en && wr_idx == LW'(i))
                mem[i] <= din;
            else if (pop_en && i < DEPTH - 1)
                mem[i] <= mem[(i + 1) % DEPTH];
        end
    end
endmodule

// File: rtl/out_mapper.sv
// Converts multicast SpiNNaker packets to AER words; drops and counts bad packets,
// and discards traffic while software dump or an AER-side stall timeout is active.
module out_mapper
    import out_mapper_pkg::*;
#(
    parameter int AER_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dump_on,
    input  logic                 dump_off,
    output logic                 dump_mode,
    input  logic [31:0]          rx_data_mask,
    input  logic                 cnt_clr,
    input  logic [PKT_W-1:0]     opkt_data,
    input  logic                 opkt_vld,
    output logic                 opkt_rdy,
    output logic [AER_WIDTH-1:0] oaer_data,
    output logic                 oaer_vld,
    input  logic                 oaer_rdy,
    output logic [15:0]          parity_err_cnt,
    output logic [15:0]          type_err_cnt
);
    pkt_t        pkt;
    logic        accept;
    logic        par_good;
    logic        par_err;
    logic        type_err;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] masked_key;
    logic [7:0]  to_cnt;
    logic        timeout;
    logic        cmd_dump;

    assign pkt        = pkt_t'(opkt_data);
    assign accept     = opkt_vld & opkt_rdy;
    assign par_good   = parity_ok(opkt_data);
    assign par_err    = accept & ~par_good;
    assign type_err   = accept & par_good & (pkt.ptype != MC_TYPE);
    assign push       = accept & par_good & (pkt.ptype == MC_TYPE) & ~dump_mode;
    assign masked_key = pkt.key & rx_data_mask;

    assign opkt_rdy = ~fifo_full | dump_mode;
    assign oaer_vld = ~fifo_empty & ~dump_mode;
    assign pop      = oaer_vld & oaer_rdy;

    out_mapper_fifo #(
        .WIDTH (AER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (dump_mode),
        .push  (push),
        .pop   (pop),
        .din   (masked_key[AER_WIDTH-1:0]),
        .dout  (oaer_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Stall watchdog: any cycle with oaer_rdy low counts down; reaching zero forces dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= TO_RELOAD;
            timeout <= 1'b0;
        end else begin
            if (oaer_rdy)           to_cnt <= TO_RELOAD;
            else if (to_cnt != '0)  to_cnt <= to_cnt - 8'd1;
            timeout <= (to_cnt == '0) & ~oaer_rdy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_dump  <= 1'b1;
            dump_mode <= 1'b1;
        end else begin
            if (dump_on)       cmd_dump <= 1'b1;
            else if (dump_off) cmd_dump <= 1'b0;
            dump_mode <= cmd_dump | timeout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_cnt <= '0;
            type_err_cnt   <= '0;
        end else if (cnt_clr) begin
            parity_err_cnt <= '0;
            type_err_cnt   <= '0;
        end else begin
            if (par_err && parity_err_cnt != CNT_MAX)
                parity_err_cnt <= parity_err_cnt + 16'd1;
            if (type_err && type_err_cnt != CNT_MAX)
                type_err_cnt <= type_err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_out_mapper.sv
// Self-checking bench for out_mapper: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_out_mapper;
    logic        clk = 1'b0;
    logic        rst;
    logic        dump_on, dump_off, dump_mode;
    logic [31:0] rx_data_mask;
    logic        cnt_clr;
    logic [71:0] opkt_data;
    logic        opkt_vld, opkt_rdy;
    logic [31:0] oaer_data;
    logic        oaer_vld, oaer_rdy;
    logic [15:0] parity_err_cnt, type_err_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_pe, exp_te;

    always #5 clk = ~clk;

    out_mapper #(.AER_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .dump_on(dump_on), .dump_off(dump_off), .dump_mode(dump_mode),
        .rx_data_mask(rx_data_mask), .cnt_clr(cnt_clr), .opkt_data(opkt_data),
        .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy), .oaer_data(oaer_data), .oaer_vld(oaer_vld),
        .oaer_rdy(oaer_rdy), .parity_err_cnt(parity_err_cnt), .type_err_cnt(type_err_cnt)
    );

    // Packet builder: parity bit chosen so the checked bits XOR to 1 (good) or 0 (bad).
    function automatic logic [71:0] mk_pkt(input logic [31:0] key, input logic [1:0] typ,
                                           input logic flag, input logic good);
        logic [71:0] d;
        logic p;
        d = {$urandom(), key, typ, 4'($urandom()), flag, 1'b0};
        p = flag ? ^d : ^d[39:0];
        d[0] = good ? ~p : p;
        return d;
    endfunction

    task automatic leave_dump();
        @(negedge clk); dump_off = 1'b1;
        @(negedge clk); dump_off = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dump_mode !== 1'b1) begin bad++; $display("FAIL reset_dump_mode: got %0b want 1", dump_mode); end
        total++; if (oaer_vld !== 1'b0) begin bad++; $display("FAIL reset_oaer_vld: got %0b want 0", oaer_vld); end
        total++; if (opkt_rdy !== 1'b1) begin bad++; $display("FAIL reset_opkt_rdy: got %0b want 1", opkt_rdy); end
        total++; if (parity_err_cnt !== 16'h0 || type_err_cnt !== 16'h0) begin bad++;
            $display("FAIL reset_counters: got %h/%h want 0/0", parity_err_cnt, type_err_cnt); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (dump_mode !== 1'b1 || oaer_vld !== 1'b0 || opkt_rdy !== 1'b1) begin bad++;
            $display("FAIL post_reset: got dump=%0b vld=%0b rdy=%0b want 1 0 1", dump_mode, oaer_vld, opkt_rdy); end
        exp_pe = 0; exp_te = 0;
    endtask

    task automatic test_basic();
        leave_dump();
        total++; if (dump_mode !== 1'b0) begin bad++; $display("FAIL basic_dump_off: got %0b want 0", dump_mode); end
        opkt_data = mk_pkt(32'h0000_1234, 2'b00, 1'b0, 1'b1);
        opkt_vld  = 1'b1;
        #1;
        total++; if (opkt_rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy: got %0b want 1", opkt_rdy); end
        @(negedge clk); opkt_vld = 1'b0;
        total++; if (oaer_vld !== 1'b1 || oaer_data !== 32'h0000_1234) begin bad++;
            $display("FAIL basic_out: got vld=%0b data=%h want 1 00001234", oaer_vld, oaer_data); end
        total++; if (parity_err_cnt !== 16'h0 || type_err_cnt !== 16'h0) begin bad++;
            $display("FAIL basic_counters: got %h/%h want 0/0", parity_err_cnt, type_err_cnt); end
        @(negedge clk);
        total++; if (oaer_vld !== 1'b0) begin bad++; $display("FAIL basic_drain: got %0b want 0", oaer_vld); end
    endtask

    task automatic test_errors();
        opkt_data = mk_pkt(32'h0000_1234, 2'b00, 1'b0, 1'b0); opkt_vld = 1'b1;
        @(negedge clk); opkt_vld = 1'b0;
        exp_pe++;
        total++; if (oaer_vld !== 1'b0) begin bad++; $display("FAIL parity_drop: got vld=%0b want 0", oaer_vld); end
        total++; if (parity_err_cnt !== exp_pe || type_err_cnt !== exp_te) begin bad++;
            $display("FAIL parity_cnt: got %h/%h want %h/%h", parity_err_cnt, type_err_cnt, exp_pe, exp_te); end
        opkt_data = mk_pkt(32'h0000_1234, 2'b01, 1'b1, 1'b1); opkt_vld = 1'b1;
        @(negedge clk); opkt_vld = 1'b0;
        exp_te++;
        total++; if (oaer_vld !== 1'b0) begin bad++; $display("FAIL type_drop: got vld=%0b want 0", oaer_vld); end
        total++; if (parity_err_cnt !== exp_pe || type_err_cnt !== exp_te) begin bad++;
            $display("FAIL type_cnt: got %h/%h want %h/%h", parity_err_cnt, type_err_cnt, exp_pe, exp_te); end
        // bad parity on a non-multicast packet counts only as a parity error
        opkt_data = mk_pkt($urandom(), 2'b11, 1'b1, 1'b0); opkt_vld = 1'b1;
        @(negedge clk); opkt_vld = 1'b0;
        exp_pe++;
        total++; if (parity_err_cnt !== exp_pe || type_err_cnt !== exp_te) begin bad++;
            $display("FAIL precedence_cnt: got %h/%h want %h/%h", parity_err_cnt, type_err_cnt, exp_pe, exp_te); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] k [4];
        logic [71:0] p [4];
        logic [31:0] got [$];
        int sent = 0;
        for (int i = 0; i < 4; i++) begin
            k[i] = $urandom();
            p[i] = mk_pkt(k[i], 2'b00, 1'($urandom()), 1'b1);
        end
        oaer_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            opkt_vld = (sent < 4); opkt_data = p[sent % 4];
            #1; if (opkt_vld && opkt_rdy) sent++;
            @(negedge clk);
        end
        total++; if (sent !== 3) begin bad++; $display("FAIL b2b_accepted: got %0d want 3", sent); end
        total++; if (opkt_rdy !== 1'b0) begin bad++; $display("FAIL b2b_full_rdy: got %0b want 0", opkt_rdy); end
        total++; if (oaer_vld !== 1'b1 || oaer_data !== k[0]) begin bad++;
            $display("FAIL b2b_head: got vld=%0b data=%h want 1 %h", oaer_vld, oaer_data, k[0]); end
        oaer_rdy = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            opkt_vld = (sent < 4); opkt_data = p[sent % 4];
            #1;
            if (oaer_vld) got.push_back(oaer_data);
            if (opkt_vld && opkt_rdy) sent++;
            @(negedge clk);
        end
        opkt_vld = 1'b0;
        total++; if (got.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== k[i]) begin bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], k[i]); end
        end
    endtask

    task automatic test_timeout();
        oaer_rdy = 1'b0;
        opkt_data = mk_pkt($urandom(), 2'b00, 1'b0, 1'b1); opkt_vld = 1'b1;
        @(negedge clk); opkt_vld = 1'b0;
        repeat (128) @(negedge clk);
        total++; if (dump_mode !== 1'b0 || oaer_vld !== 1'b1) begin bad++;
            $display("FAIL timeout_early: got dump=%0b vld=%0b want 0 1", dump_mode, oaer_vld); end
        @(negedge clk);
        total++; if (dump_mode !== 1'b1 || oaer_vld !== 1'b0 || opkt_rdy !== 1'b1) begin bad++;
            $display("FAIL timeout_dump: got dump=%0b vld=%0b rdy=%0b want 1 0 1", dump_mode, oaer_vld, opkt_rdy); end
        @(negedge clk); oaer_rdy = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dump_mode !== 1'b0 || oaer_vld !== 1'b0) begin bad++;
            $display("FAIL timeout_recover: got dump=%0b vld=%0b want 0 0", dump_mode, oaer_vld); end
    endtask

    task automatic test_mask_dump();
        rx_data_mask = 32'h0000_00FF;
        opkt_data = mk_pkt(32'hABCD_EF12, 2'b00, 1'b1, 1'b1); opkt_vld = 1'b1;
        @(negedge clk); opkt_vld = 1'b0; rx_data_mask = 32'hFFFF_FFFF;
        total++; if (oaer_vld !== 1'b1 || oaer_data !== 32'h0000_0012) begin bad++;
            $display("FAIL mask_out: got vld=%0b data=%h want 1 00000012", oaer_vld, oaer_data); end
        dump_on = 1'b1; dump_off = 1'b1;
        @(negedge clk); dump_on = 1'b0; dump_off = 1'b0;
        @(negedge clk);
        total++; if (dump_mode !== 1'b1) begin bad++; $display("FAIL dump_on_wins: got %0b want 1", dump_mode); end
        opkt_data = mk_pkt($urandom(), 2'b00, 1'b0, 1'b1); opkt_vld = 1'b1;
        @(negedge clk);
        opkt_data = mk_pkt($urandom(), 2'b10, 1'b0, 1'b1);
        @(negedge clk); opkt_vld = 1'b0;
        exp_te++;
        total++; if (oaer_vld !== 1'b0 || opkt_rdy !== 1'b1) begin bad++;
            $display("FAIL dump_discard: got vld=%0b rdy=%0b want 0 1", oaer_vld, opkt_rdy); end
        total++; if (parity_err_cnt !== exp_pe || type_err_cnt !== exp_te) begin bad++;
            $display("FAIL dump_counts: got %h/%h want %h/%h", parity_err_cnt, type_err_cnt, exp_pe, exp_te); end
        leave_dump();
        total++; if (dump_mode !== 1'b0 || oaer_vld !== 1'b0) begin bad++;
            $display("FAIL dump_exit: got dump=%0b vld=%0b want 0 0", dump_mode, oaer_vld); end
    endtask

    task automatic test_reset_mid();
        oaer_rdy = 1'b0;
        opkt_data = mk_pkt($urandom(), 2'b00, 1'b0, 1'b1); opkt_vld = 1'b1;
        @(negedge clk);
        opkt_data = mk_pkt($urandom(), 2'b00, 1'b1, 1'b1);
        @(negedge clk); opkt_vld = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; oaer_rdy = 1'b1;
        exp_pe = 0; exp_te = 0;
        total++; if (oaer_vld !== 1'b0 || dump_mode !== 1'b1 || opkt_rdy !== 1'b1) begin bad++;
            $display("FAIL midrst_state: got vld=%0b dump=%0b rdy=%0b want 0 1 1", oaer_vld, dump_mode, opkt_rdy); end
        leave_dump();
        total++; if (oaer_vld !== 1'b0) begin bad++; $display("FAIL midrst_empty: got vld=%0b want 0", oaer_vld); end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] key;
        logic [1:0]  typ;
        logic        good;
        for (int c = 0; c < 400; c++) begin
            key  = $urandom();
            typ  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            good = ($urandom_range(0, 4) != 0);
            opkt_data    = mk_pkt(key, typ, 1'($urandom()), good);
            opkt_vld     = ($urandom_range(0, 3) != 0);
            oaer_rdy     = ($urandom_range(0, 2) != 0);
            rx_data_mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom();
            #1;
            total++; if (opkt_rdy !== (q.size() < 3)) begin bad++;
                $display("FAIL rnd_rdy c=%0d: got %0b want %0b", c, opkt_rdy, q.size() < 3); end
            total++; if (oaer_vld !== (q.size() != 0)) begin bad++;
                $display("FAIL rnd_vld c=%0d: got %0b want %0b", c, oaer_vld, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (oaer_data !== q[0]) begin bad++;
                    $display("FAIL rnd_data c=%0d: got %h want %h", c, oaer_data, q[0]); end
            end
            total++; if (parity_err_cnt !== exp_pe || type_err_cnt !== exp_te) begin bad++;
                $display("FAIL rnd_cnt c=%0d: got %h/%h want %h/%h", c, parity_err_cnt, type_err_cnt, exp_pe, exp_te); end
            if (opkt_vld && q.size() < 3) begin
                if (oaer_rdy && q.size() != 0) void'(q.pop_front());
                if (!good) exp_pe++;
                else if (typ != 2'b00) exp_te++;
                else q.push_back(key & rx_data_mask);
            end else if (oaer_rdy && q.size() != 0) begin
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        opkt_vld = 1'b0; oaer_rdy = 1'b1; rx_data_mask = 32'hFFFF_FFFF;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturate();
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        opkt_data = mk_pkt($urandom(), 2'b00, 1'b1, 1'b0); opkt_vld = 1'b1;
        repeat (65534) @(negedge clk);
        total++; if (parity_err_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_near: got %h want fffe", parity_err_cnt); end
        @(negedge clk);
        total++; if (parity_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_max: got %h want ffff", parity_err_cnt); end
        repeat (5) @(negedge clk);
        total++; if (parity_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", parity_err_cnt); end
        opkt_data = mk_pkt($urandom(), 2'b01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (type_err_cnt !== 16'd3) begin bad++; $display("FAIL sat_type: got %h want 0003", type_err_cnt); end
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; opkt_vld = 1'b0;
        total++; if (parity_err_cnt !== 16'h0 || type_err_cnt !== 16'h0) begin bad++;
            $display("FAIL clr_wins: got %h/%h want 0/0", parity_err_cnt, type_err_cnt); end
    endtask

    initial begin
        rst = 1'b1; dump_on = 1'b0; dump_off = 1'b0; rx_data_mask = 32'hFFFF_FFFF;
        cnt_clr = 1'b0; opkt_data = '0; opkt_vld = 1'b0; oaer_rdy = 1'b1;
        exp_pe = 0; exp_te = 0;
        test_reset();
        test_basic();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_mask_dump();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
